// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receiver and the future
// transmitter.
//   - State encoding for the receive FSM (3 bits).
//   - Default bit period in clocks (50 MHz / 115200 baud).
//   - Frame shape: 8 data bits, 1 stop bit.
//   - half_bit(): start-bit confirmation point in clocks.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t START      = 3'd1;
  localparam state_t DATA       = 3'd2;
  localparam state_t STOP       = 3'd3;
  localparam state_t BREAK_WAIT = 3'd4;

  // Counter value at which the start bit is re-checked (middle of the bit).
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte stream out.
//   rx        - serial line, idle high
//   data      - last correctly framed byte
//   rdy       - one-cycle strobe, data just updated
//   frame_err - one-cycle strobe, stop bit sampled low
//   busy      - receiver is inside a frame
// master: the receiver. slave: line driver / byte consumer (FIFO).
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, output rdy, output frame_err, output busy);
  modport slave  (output rx, input data, input rdy, input frame_err, input busy);
endinterface

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for one asynchronous input.
//   clk     - destination clock
//   rst     - synchronous active-high reset, loads RESET_VAL into both flops
//   async_i - asynchronous input
//   sync_o  - synchronized output, two clocks of latency
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, line idle high.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - uart_rx_if.master: rx in; data, rdy, frame_err, busy out
// Each bit is sampled at its midpoint by a clock-cycle counter. A start bit
// that is gone at its midpoint is treated as a glitch. A low stop bit raises
// frame_err and parks the FSM until the line returns high, so a held-low
// break produces a single error instead of a stream of frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int CNT_W        = 16
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic             rx_s;
  state_t           state_q,     state_d;
  logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             rdy_q,       rdy_d;
  logic             frame_err_q, frame_err_d;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.rx),
    .sync_o  (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rdy_d       = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          // From here on the counter is phased to bit midpoints.
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;   // wraps to 0 after the last bit
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST_CNT) begin
          // Leaving at mid-stop gives half a bit to catch a back-to-back start.
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            rdy_d   = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK_WAIT;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      BREAK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
